// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the single-clock frame FIFO.
package sync_fifo_pkg;

    // Write-side frame states: between frames, frame open, discarding a frame
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        DROP  = 2'd2
    } wr_state_t;

    // Pointer subtraction; callers truncate the result to their pointer width,
    // which yields the modulo-2^(PTR_LEN+1) difference including the wrap bit.
    function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/frame_fifo_mem.sv
// Flop-array storage for the frame FIFO: one write port, one combinational read port.
module frame_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int WORD_W = 9,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [WORD_W-1:0] i_wrData,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [WORD_W-1:0] o_rdData
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    // Store one word per accepted write; cleared on reset so the head reads as zero
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/sync_frame_fifo.sv
// Single-clock frame-aware FIFO: words become readable only once their frame's
// last beat is written; aborted or overflowed frames are rewound.
module sync_frame_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SIZE      = 16,
    parameter int PTR_LEN   = $clog2(SIZE),
    parameter int AF_THRESH = SIZE - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 1
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               w_en,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               w_last,
    input  logic               w_abort,
    output logic               full,
    input  logic               r_en,
    output logic [WIDTH-1:0]   data_out,
    output logic               r_last,
    output logic               r_valid,
    output logic               empty,
    output logic [PTR_LEN:0]   rd_level,
    output logic [PTR_LEN:0]   wr_level,
    output logic               almost_full,
    output logic               almost_empty,
    output logic               overflow,
    output logic               underflow,
    input  logic               clr_flags
);

    localparam int PTR_W = PTR_LEN + 1;
    localparam logic [PTR_W-1:0] SIZE_LVL = PTR_W'(SIZE);
    localparam logic [PTR_W-1:0] AF_LVL   = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_LVL   = PTR_W'(AE_THRESH);

    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_cmtPtr;
    logic [PTR_W-1:0] r_rdPtr;
    wr_state_t        r_state;
    logic             r_overflow;
    logic             r_underflow;

    logic [PTR_W-1:0] w_wrLevel;
    logic [PTR_W-1:0] w_rdLevel;
    logic [PTR_W-1:0] w_wrPtrInc;
    logic             w_full;
    logic             w_empty;
    logic             w_wrAccept;
    logic             w_ovfEvent;
    logic             w_pop;
    logic             w_unfEvent;
    logic [WIDTH:0]   w_rdWord;

    // Levels and flags come only from registered pointers, so a pop never
    // frees a slot for a write in the same cycle.
    assign w_wrLevel  = PTR_W'(ptr_diff(32'(r_wrPtr), 32'(r_rdPtr)));
    assign w_rdLevel  = PTR_W'(ptr_diff(32'(r_cmtPtr), 32'(r_rdPtr)));
    assign w_wrPtrInc = r_wrPtr + PTR_W'(1);
    assign w_full     = (w_wrLevel == SIZE_LVL);
    assign w_empty    = (w_rdLevel == '0);

    // Abort outranks everything on the write side; a full FIFO turns the beat
    // into an overflow instead of a store.
    assign w_wrAccept = w_en && !w_full && (r_state != DROP) && !w_abort;
    assign w_ovfEvent = w_en && w_full && (r_state != DROP) && !w_abort;
    assign w_pop      = r_en && !w_empty;
    assign w_unfEvent = r_en && w_empty;

    assign full         = w_full;
    assign empty        = w_empty;
    assign wr_level     = w_wrLevel;
    assign rd_level     = w_rdLevel;
    assign almost_full  = (w_wrLevel >= AF_LVL);
    assign almost_empty = (w_rdLevel <= AE_LVL);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    frame_fifo_mem #(
        .WORD_W (WIDTH + 1),
        .DEPTH  (SIZE),
        .ADDR_W (PTR_LEN)
    ) u_mem (
        .clk      (clk),
        .arst_n   (arst_n),
        .i_wrEn   (w_wrAccept),
        .i_wrAddr (r_wrPtr[PTR_LEN-1:0]),
        .i_wrData ({w_last, data_in}),
        .i_rdAddr (r_rdPtr[PTR_LEN-1:0]),
        .o_rdData (w_rdWord)
    );

    // Write-side frame tracking: advance, commit on last beat, rewind on abort/overflow
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wrPtr  <= '0;
            r_cmtPtr <= '0;
            r_state  <= IDLE;
        end else if (w_abort) begin
            r_wrPtr <= r_cmtPtr;
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE, FRAME: begin
                    if (w_ovfEvent) begin
                        r_wrPtr <= r_cmtPtr;
                        r_state <= w_last ? IDLE : DROP;
                    end else if (w_wrAccept) begin
                        r_wrPtr <= w_wrPtrInc;
                        if (w_last) begin
                            r_cmtPtr <= w_wrPtrInc;
                            r_state  <= IDLE;
                        end else begin
                            r_state <= FRAME;
                        end
                    end
                end
                DROP: begin
                    if (w_en && w_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read pointer advances on every successful pop in either read mode
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_rdPtr <= '0;
        end else if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
        end
    end

    // Sticky error flags; a set event in the same cycle beats the clear
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovfEvent) begin
                r_overflow <= 1'b1;
            end else if (clr_flags) begin
                r_overflow <= 1'b0;
            end
            if (w_unfEvent) begin
                r_underflow <= 1'b1;
            end else if (clr_flags) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = w_rdWord[WIDTH-1:0];
            assign r_last   = w_rdWord[WIDTH];
            assign r_valid  = !w_empty;
        end else begin : g_regRead
            logic [WIDTH-1:0] r_dataOut;
            logic             r_lastOut;
            logic             r_validOut;

            // Registered read: capture the head on a pop, valid for exactly one cycle
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    r_dataOut  <= '0;
                    r_lastOut  <= 1'b0;
                    r_validOut <= 1'b0;
                end else begin
                    r_validOut <= w_pop;
                    if (w_pop) begin
                        r_dataOut <= w_rdWord[WIDTH-1:0];
                        r_lastOut <= w_rdWord[WIDTH];
                    end
                end
            end

            assign data_out = r_dataOut;
            assign r_last   = r_lastOut;
            assign r_valid  = r_validOut;
        end
    endgenerate

endmodule

// File: tb/tb_sync_frame_fifo.sv
// Scoreboard bench for sync_frame_fifo: one FWFT instance against a frame-level
// queue model, one registered-read instance with its own expected-word queue.
module tb_sync_frame_fifo;

    localparam int W  = 8;
    localparam int SZ = 8;

    logic clk;
    logic arst_n;

    // FWFT instance signals
    logic         we1, wl1, wa1, re1, clr1;
    logic [W-1:0] d1, dout1;
    logic         full1, rl1, rv1, empty1, af1, ae1, ovf1, unf1;
    logic [3:0]   rdl1, wrl1;

    // Registered-read instance signals
    logic         we0, wl0, re0;
    logic         wa0, clr0;
    logic [W-1:0] d0, dout0;
    logic         full0, rl0, rv0, empty0, af0, ae0, ovf0, unf0;
    logic [3:0]   rdl0, wrl0;

    int vecs = 0;
    int errs = 0;

    // Frame-level reference model for the FWFT instance
    int         curCmt, curPend, nxtCmt, nxtPend;
    bit         curOvf, curUnf, nxtOvf, nxtUnf, dropping;
    logic [8:0] pendQ[$];
    logic [8:0] sbQ[$];
    bit         monEn;

    // Model for the registered-read instance
    logic [8:0] pend0[$];
    logic [8:0] avail0[$];
    logic [8:0] q0[$];
    bit         mon0En;

    sync_frame_fifo #(.WIDTH(W), .SIZE(SZ), .FWFT(1)) dut1 (
        .clk(clk), .arst_n(arst_n), .w_en(we1), .data_in(d1), .w_last(wl1),
        .w_abort(wa1), .full(full1), .r_en(re1), .data_out(dout1), .r_last(rl1),
        .r_valid(rv1), .empty(empty1), .rd_level(rdl1), .wr_level(wrl1),
        .almost_full(af1), .almost_empty(ae1), .overflow(ovf1), .underflow(unf1),
        .clr_flags(clr1)
    );

    sync_frame_fifo #(.WIDTH(W), .SIZE(SZ), .FWFT(0)) dut0 (
        .clk(clk), .arst_n(arst_n), .w_en(we0), .data_in(d0), .w_last(wl0),
        .w_abort(wa0), .full(full0), .r_en(re0), .data_out(dout0), .r_last(rl0),
        .r_valid(rv0), .empty(empty0), .rd_level(rdl0), .wr_level(wrl0),
        .almost_full(af0), .almost_empty(ae0), .overflow(ovf0), .underflow(unf0),
        .clr_flags(clr0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearModel();
        curCmt = 0; curPend = 0; nxtCmt = 0; nxtPend = 0;
        curOvf = 0; curUnf = 0; nxtOvf = 0; nxtUnf = 0; dropping = 0;
        pendQ.delete(); sbQ.delete();
        pend0.delete(); avail0.delete(); q0.delete();
        we1 = 0; wl1 = 0; wa1 = 0; re1 = 0; clr1 = 0; d1 = '0;
        we0 = 0; wl0 = 0; re0 = 0; d0 = '0;
    endtask

    // One cycle on the FWFT instance: adopt the model state for the edge just
    // passed, drive new inputs, then predict the effect of the coming edge.
    task automatic applyStimulus(input bit we, input bit wl, input bit wa,
                                 input logic [7:0] d, input bit re, input bit clr);
        bit isFull, isEmpty, ovfEv;
        @(posedge clk);
        #1;
        curCmt = nxtCmt; curPend = nxtPend; curOvf = nxtOvf; curUnf = nxtUnf;
        we1 = we; wl1 = wl; wa1 = wa; d1 = d; re1 = re; clr1 = clr;
        isFull  = (curCmt + curPend) == SZ;
        isEmpty = (curCmt == 0);
        ovfEv   = 0;
        nxtCmt  = curCmt - ((re && !isEmpty) ? 1 : 0);
        nxtUnf  = (re && isEmpty) ? 1'b1 : (clr ? 1'b0 : curUnf);
        if (wa) begin
            pendQ.delete();
            dropping = 0;
        end else if (we) begin
            if (dropping) begin
                if (wl) dropping = 0;
            end else if (isFull) begin
                ovfEv = 1;
                pendQ.delete();
                dropping = !wl;
            end else begin
                pendQ.push_back({wl, d});
                if (wl) begin
                    nxtCmt += pendQ.size();
                    foreach (pendQ[k]) sbQ.push_back(pendQ[k]);
                    pendQ.delete();
                end
            end
        end
        nxtPend = pendQ.size();
        nxtOvf  = ovfEv ? 1'b1 : (clr ? 1'b0 : curOvf);
    endtask

    task automatic idle1(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 8'h00, 0, 0);
    endtask

    // One cycle on the registered-read instance; reads see only frames committed earlier
    task automatic applyStim0(input bit we, input bit wl, input logic [7:0] d, input bit re);
        @(posedge clk);
        #1;
        we0 = we; wl0 = wl; d0 = d; re0 = re;
        if (re && avail0.size() > 0) q0.push_back(avail0.pop_front());
        if (we) begin
            pend0.push_back({wl, d});
            if (wl) begin
                foreach (pend0[k]) avail0.push_back(pend0[k]);
                pend0.delete();
            end
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst empty", 32'(empty1), 1);
        checkOutput("rst full", 32'(full1), 0);
        checkOutput("rst rd_level", 32'(rdl1), 0);
        checkOutput("rst wr_level", 32'(wrl1), 0);
        checkOutput("rst almost_empty", 32'(ae1), 1);
        checkOutput("rst almost_full", 32'(af1), 0);
        checkOutput("rst r_valid", 32'(rv1), 0);
        checkOutput("rst data_out", 32'(dout1), 0);
        checkOutput("rst r_last", 32'(rl1), 0);
        checkOutput("rst overflow", 32'(ovf1), 0);
        checkOutput("rst underflow", 32'(unf1), 0);
        checkOutput("rst r_valid0", 32'(rv0), 0);
        checkOutput("rst data_out0", 32'(dout0), 0);
    endtask

    // Monitor for the FWFT instance: flags vs model every cycle, head data vs scoreboard
    always @(negedge clk) begin
        if (monEn) begin
            checkOutput("wr_level", 32'(wrl1), 32'(curCmt + curPend));
            checkOutput("rd_level", 32'(rdl1), 32'(curCmt));
            checkOutput("full", 32'(full1), 32'((curCmt + curPend) == SZ));
            checkOutput("empty", 32'(empty1), 32'(curCmt == 0));
            checkOutput("almost_full", 32'(af1), 32'((curCmt + curPend) >= SZ - 2));
            checkOutput("almost_empty", 32'(ae1), 32'(curCmt <= 2));
            checkOutput("overflow", 32'(ovf1), 32'(curOvf));
            checkOutput("underflow", 32'(unf1), 32'(curUnf));
            checkOutput("r_valid", 32'(rv1), 32'(curCmt != 0));
            if (rv1) begin
                if (sbQ.size() == 0) begin
                    vecs++; errs++;
                    $display("[TB] FAIL head: r_valid=1 but no word expected, data_out=%0h", dout1);
                end else begin
                    checkOutput("data_out", 32'(dout1), 32'(sbQ[0][7:0]));
                    checkOutput("r_last", 32'(rl1), 32'(sbQ[0][8]));
                    if (re1) void'(sbQ.pop_front());
                end
            end
        end
    end

    // Monitor for the registered-read instance: every valid beat must match the next expected word
    always @(negedge clk) begin
        if (mon0En && rv0) begin
            if (q0.size() == 0) begin
                vecs++; errs++;
                $display("[TB] FAIL rd0: unexpected r_valid, data_out=%0h expected none", dout0);
            end else begin
                logic [8:0] e;
                e = q0.pop_front();
                checkOutput("rd0 data_out", 32'(dout0), 32'(e[7:0]));
                checkOutput("rd0 r_last", 32'(rl0), 32'(e[8]));
            end
        end
    end

    initial begin
        wa0 = 0; clr0 = 0;
        monEn = 0; mon0En = 0;
        clearModel();
        arst_n = 0;
        #21;
        checkResetOutputs();
        #1;
        arst_n = 1; monEn = 1; mon0En = 1;

        // Three-beat frame stays invisible until its last beat is written
        applyStimulus(1, 0, 0, 8'hA1, 0, 0);
        applyStimulus(1, 0, 0, 8'hA2, 0, 0);
        applyStimulus(1, 1, 0, 8'hA3, 0, 0);
        @(negedge clk);
        checkOutput("A empty before commit", 32'(empty1), 1);
        idle1(1);
        @(negedge clk);
        checkOutput("A rd_level", 32'(rdl1), 3);
        checkOutput("A head", 32'(dout1), 32'h A1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 8'h00, 1, 0);
        idle1(1);
        @(negedge clk);
        checkOutput("A empty after pops", 32'(empty1), 1);

        // Abort rewinds the open frame without flagging overflow
        applyStimulus(1, 0, 0, 8'hB1, 0, 0);
        applyStimulus(1, 0, 0, 8'hB2, 0, 0);
        applyStimulus(1, 1, 1, 8'hB3, 0, 0);
        idle1(1);
        @(negedge clk);
        checkOutput("abort wr_level", 32'(wrl1), 0);
        checkOutput("abort empty", 32'(empty1), 1);
        checkOutput("abort overflow", 32'(ovf1), 0);

        // Ten-beat frame overflows at beat 9 and drops to its last beat
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, i == 9, 0, 8'(8'h30 + i), 0, 0);
            @(negedge clk);
            if (i == 8) checkOutput("long full", 32'(full1), 1);
            if (i == 9) checkOutput("long overflow", 32'(ovf1), 1);
        end
        applyStimulus(1, 0, 0, 8'h55, 0, 0);
        applyStimulus(1, 1, 0, 8'h66, 0, 0);
        idle1(1);
        @(negedge clk);
        checkOutput("post-drop rd_level", 32'(rdl1), 2);
        applyStimulus(0, 0, 0, 8'h00, 1, 1);
        applyStimulus(0, 0, 0, 8'h00, 1, 0);

        // Underflow is sticky until cleared
        applyStimulus(0, 0, 0, 8'h00, 1, 0);
        idle1(1);
        @(negedge clk);
        checkOutput("underflow set", 32'(unf1), 1);
        idle1(1);
        @(negedge clk);
        checkOutput("underflow sticky", 32'(unf1), 1);
        applyStimulus(0, 0, 0, 8'h00, 0, 1);
        idle1(1);
        @(negedge clk);
        checkOutput("underflow cleared", 32'(unf1), 0);

        // Threshold flags, then a reset in the middle of a frame
        for (int i = 0; i < 6; i++) applyStimulus(1, i == 5, 0, 8'(8'h70 + i), 0, 0);
        idle1(1);
        @(negedge clk);
        checkOutput("six almost_full", 32'(af1), 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 8'h00, 1, 0);
        idle1(1);
        @(negedge clk);
        checkOutput("two rd_level", 32'(rdl1), 2);
        checkOutput("two almost_empty", 32'(ae1), 1);
        applyStimulus(1, 0, 0, 8'hC1, 0, 0);
        applyStimulus(1, 0, 0, 8'hC2, 0, 0);
        #1;
        monEn = 0; mon0En = 0;
        arst_n = 0;
        #1;
        checkResetOutputs();
        clearModel();
        @(negedge clk);
        #2;
        arst_n = 1; monEn = 1; mon0En = 1;

        // Randomized traffic against the frame-level model
        for (int c = 0; c < 1500; c++) begin
            applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 15,
                          $urandom_range(0, 99) < 3, 8'($urandom), $urandom_range(0, 99) < 30,
                          $urandom_range(0, 99) < 5);
        end
        applyStimulus(0, 0, 1, 8'h00, 0, 0);
        for (int g = 0; g < 40 && nxtCmt > 0; g++) applyStimulus(0, 0, 0, 8'h00, 1, 0);
        idle1(2);
        @(negedge clk);
        checkOutput("scoreboard drained", 32'(sbQ.size()), 0);
        monEn = 0;

        // Registered read: data follows each r_en by one cycle
        applyStim0(1, 0, 8'h11, 0);
        applyStim0(1, 1, 8'h22, 0);
        applyStim0(0, 0, 8'h00, 0);
        applyStim0(0, 0, 8'h00, 1);
        @(negedge clk);
        checkOutput("rd0 valid before", 32'(rv0), 0);
        applyStim0(0, 0, 8'h00, 1);
        @(negedge clk);
        checkOutput("rd0 valid 1", 32'(rv0), 1);
        checkOutput("rd0 data 1", 32'(dout0), 32'h11);
        applyStim0(0, 0, 8'h00, 0);
        @(negedge clk);
        checkOutput("rd0 valid 2", 32'(rv0), 1);
        checkOutput("rd0 data 2", 32'(dout0), 32'h22);
        applyStim0(0, 0, 8'h00, 0);
        @(negedge clk);
        checkOutput("rd0 valid after", 32'(rv0), 0);
        checkOutput("rd0 data held", 32'(dout0), 32'h22);

        for (int r = 0; r < 25; r++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) applyStim0(1, b == len - 1, 8'($urandom), 0);
            for (int g = 0; g < 60 && (avail0.size() > 0 || b_pending0()); g++) begin
                applyStim0(0, 0, 8'h00, 1'($urandom_range(0, 1)));
            end
            applyStim0(0, 0, 8'h00, 0);
            applyStim0(0, 0, 8'h00, 0);
        end
        @(negedge clk);
        checkOutput("rd0 queue drained", 32'(q0.size()), 0);
        checkOutput("rd0 empty", 32'(empty0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    // The commit edge of the last frame has not happened until one call after its last beat
    function automatic bit b_pending0();
        return (we0 && wl0);
    endfunction

endmodule
